// File: rtl/bp_boot_rom_arbiter_if.sv
// rtl/bp_boot_rom_arbiter_if.sv - requester-side bus of the boot ROM arbiter
// Per-requester request lanes plus the shared response; the arbiter takes the slave modport.
interface bp_boot_rom_arbiter_if #(
  parameter int num_req_p    = 2,
  parameter int addr_width_p = 9,
  parameter int width_p      = 512
);
  logic [num_req_p-1:0]                   v_i;
  logic [num_req_p-1:0][addr_width_p-1:0] addr_i;
  logic [num_req_p-1:0]                   last_i;
  logic [num_req_p-1:0]                   ready_o;
  logic [num_req_p-1:0]                   v_o;
  logic [width_p-1:0]                     data_o;

  modport master (output v_i, addr_i, last_i, input ready_o, v_o, data_o);
  modport slave  (input v_i, addr_i, last_i, output ready_o, v_o, data_o);
endinterface

// File: rtl/bp_boot_rom_arbiter.sv
// rtl/bp_boot_rom_arbiter.sv - round-robin burst-locking arbiter in front of one boot ROM
// Optional lock watchdog enabled by defining BP_BOOT_ROM_ARB_LOCK_TIMEOUT_EN.
module bp_boot_rom_arbiter #(
  parameter int num_req_p      = 2,
  parameter int addr_width_p   = 9,
  parameter int width_p        = 512,
  parameter int lock_timeout_p = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bp_boot_rom_arbiter_if.slave    req,
  output logic [addr_width_p-1:0] rom_addr_o,
  input  logic [width_p-1:0]      rom_data_i,
  output logic                    err_o
);

  localparam int idx_w = $clog2(num_req_p);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state_r, state_n;
  logic [idx_w-1:0] rr_ptr_r, rr_ptr_n;
  logic [idx_w-1:0] owner_r, owner_n;
  logic [idx_w-1:0] gnt_idx, cand;
  logic [idx_w:0]   sum;
  logic             gnt_v, accept, last_beat, timeout;

  function automatic logic [idx_w-1:0] inc_wrap(input logic [idx_w-1:0] i);
    return (int'(i) == num_req_p - 1) ? '0 : i + 1'b1;
  endfunction

  // Descending scan so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    sum     = '0;
    if (state_r == LOCKED) begin
      gnt_v   = 1'b1;
      gnt_idx = owner_r;
    end else begin
      for (int i = num_req_p - 1; i >= 0; i--) begin
        sum = {1'b0, rr_ptr_r} + (idx_w+1)'(i);
        if (sum >= (idx_w+1)'(num_req_p))
          sum = sum - (idx_w+1)'(num_req_p);
        cand = sum[idx_w-1:0];
        if (req.v_i[cand]) begin
          gnt_v   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (reset_i)
      gnt_v = 1'b0;
  end

  assign accept      = gnt_v & req.v_i[gnt_idx];
  assign last_beat   = req.last_i[gnt_idx];
  assign req.ready_o = gnt_v ? (num_req_p'(1) << gnt_idx) : '0;
  assign rom_addr_o  = gnt_v ? req.addr_i[gnt_idx] : '0;

`ifdef BP_BOOT_ROM_ARB_LOCK_TIMEOUT_EN
  localparam int cnt_w = $clog2(lock_timeout_p + 1);

  logic [cnt_w-1:0] idle_cnt_r, idle_cnt_n;
  logic             err_r;

  // Fires on the lock_timeout_p-th consecutive LOCKED cycle without an owner beat.
  assign timeout = (state_r == LOCKED) && !accept &&
                   (idle_cnt_r == cnt_w'(lock_timeout_p - 1));

  always_comb begin
    idle_cnt_n = idle_cnt_r;
    if (accept || timeout)
      idle_cnt_n = '0;
    else if (state_r == LOCKED)
      idle_cnt_n = idle_cnt_r + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idle_cnt_r <= '0;
      err_r      <= 1'b0;
    end else begin
      idle_cnt_r <= idle_cnt_n;
      err_r      <= timeout;
    end
  end

  assign err_o = err_r;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_n  = state_r;
    rr_ptr_n = rr_ptr_r;
    owner_n  = owner_r;
    if (accept) begin
      if (last_beat) begin
        state_n  = IDLE;
        rr_ptr_n = inc_wrap(gnt_idx);
      end else begin
        state_n = LOCKED;
        owner_n = gnt_idx;
      end
    end else if (timeout) begin
      state_n  = IDLE;
      rr_ptr_n = inc_wrap(owner_r);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      owner_r    <= '0;
      req.v_o    <= '0;
      req.data_o <= '0;
    end else begin
      state_r  <= state_n;
      rr_ptr_r <= rr_ptr_n;
      owner_r  <= owner_n;
      req.v_o  <= accept ? req.ready_o : '0;
      if (accept)
        req.data_o <= rom_data_i;
    end
  end

endmodule

// File: tb/tb_bp_boot_rom_arbiter.sv
// tb/tb_bp_boot_rom_arbiter.sv - table, directed and random checks of the boot ROM arbiter
// Three requesters exercise non-power-of-two pointer wrap.
module tb_bp_boot_rom_arbiter;

  localparam int N  = 3;
  localparam int AW = 9;
  localparam int W  = 64;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [AW-1:0] rom_addr_o;
  logic [W-1:0]  rom_data_i;
  logic          err_o;

  always #5 clk = ~clk;

  bp_boot_rom_arbiter_if #(.num_req_p(N), .addr_width_p(AW), .width_p(W)) bus ();

  bp_boot_rom_arbiter #(
    .num_req_p(N), .addr_width_p(AW), .width_p(W), .lock_timeout_p(T)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .req(bus),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .err_o(err_o)
  );

  function automatic logic [W-1:0] rom_f(input logic [AW-1:0] a);
    return {32'hB007_0000 | 32'(a), ~(32'(a) * 32'h0101_0101)};
  endfunction

  assign rom_data_i = rom_f(rom_addr_o);

  int n_vec = 0;
  int n_err = 0;

  int         m_locked, m_owner, m_rr, m_idle;
  logic [2:0] m_vo;
  logic [W-1:0] m_data;
  logic       m_err;

  typedef struct {
    logic [2:0]    v;
    logic [AW-1:0] a0, a1, a2;
    logic [2:0]    last;
    logic [2:0]    ready;
    logic [AW-1:0] raddr;
    logic [2:0]    vo;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_locked = 0; m_owner = 0; m_rr = 0; m_idle = 0;
    m_vo = '0; m_data = '0; m_err = 1'b0;
  endtask

  // Drive one cycle, compare against the reference model, then advance the model.
  task automatic step(input logic [2:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic [2:0] last);
    logic [AW-1:0] av[3];
    int            g;
    logic [2:0]    er;
    logic [AW-1:0] ea;
    av[0] = a0; av[1] = a1; av[2] = a2;
    @(negedge clk);
    bus.v_i = v; bus.addr_i[0] = a0; bus.addr_i[1] = a1; bus.addr_i[2] = a2; bus.last_i = last;
    #1;
    g = -1;
    if (m_locked != 0) g = m_owner;
    else for (int off = 0; off < N; off++) begin
      int k;
      k = (m_rr + off) % N;
      if (g < 0 && ((v >> k) & 3'b001) != 3'b000) g = k;
    end
    er = (g >= 0) ? (3'b001 << g) : 3'b000;
    ea = (g >= 0) ? av[g] : '0;
    chk("ready_o", bus.ready_o, er);
    chk("rom_addr_o", rom_addr_o, ea);
    chk("v_o", bus.v_o, m_vo);
    chk("data_o", bus.data_o, m_data);
    chk("err_o", err_o, m_err);
    m_err = 1'b0;
    if (g >= 0 && ((v >> g) & 3'b001) != 3'b000) begin
      m_vo = er; m_data = rom_f(av[g]); m_idle = 0;
      if (((last >> g) & 3'b001) != 3'b000) begin m_locked = 0; m_rr = (g + 1) % N; end
      else begin m_locked = 1; m_owner = g; end
    end else begin
      m_vo = '0;
      if (m_locked != 0) begin
        m_idle++;
`ifdef BP_BOOT_ROM_ARB_LOCK_TIMEOUT_EN
        if (m_idle == T) begin
          m_locked = 0; m_rr = (m_owner + 1) % N; m_err = 1'b1; m_idle = 0;
        end
`endif
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1; bus.v_i = '1;
    #1;
    chk("rst_ready_o", bus.ready_o, 3'b000);
    chk("rst_v_o", bus.v_o, 3'b000);
    chk("rst_data_o", bus.data_o, '0);
    chk("rst_err_o", err_o, 1'b0);
    @(negedge clk);
    reset_i = 1'b0; bus.v_i = '0;
    m_reset();
  endtask

  initial begin
    bus.v_i = '0; bus.last_i = '0;
    bus.addr_i[0] = '0; bus.addr_i[1] = '0; bus.addr_i[2] = '0;
    m_reset();

    tbl[0]  = '{3'b001, 9'd5, 9'd0, 9'd0, 3'b001, 3'b001, 9'd5, 3'b000};
    tbl[1]  = '{3'b000, 9'd0, 9'd0, 9'd0, 3'b000, 3'b000, 9'd0, 3'b001};
    tbl[2]  = '{3'b011, 9'd1, 9'd2, 9'd0, 3'b011, 3'b010, 9'd2, 3'b000};
    tbl[3]  = '{3'b011, 9'd1, 9'd2, 9'd0, 3'b011, 3'b001, 9'd1, 3'b010};
    tbl[4]  = '{3'b011, 9'd1, 9'd2, 9'd0, 3'b011, 3'b010, 9'd2, 3'b001};
    tbl[5]  = '{3'b111, 9'd1, 9'd2, 9'd7, 3'b111, 3'b100, 9'd7, 3'b010};
    tbl[6]  = '{3'b110, 9'd1, 9'd3, 9'd7, 3'b000, 3'b010, 9'd3, 3'b100};
    tbl[7]  = '{3'b101, 9'd1, 9'd3, 9'd7, 3'b000, 3'b010, 9'd3, 3'b010};
    tbl[8]  = '{3'b010, 9'd1, 9'd4, 9'd7, 3'b010, 3'b010, 9'd4, 3'b000};
    tbl[9]  = '{3'b001, 9'd9, 9'd4, 9'd7, 3'b001, 3'b001, 9'd9, 3'b010};
    tbl[10] = '{3'b000, 9'd0, 9'd0, 9'd0, 3'b000, 3'b000, 9'd0, 3'b001};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].last);
      chk("tbl_ready", bus.ready_o, tbl[i].ready);
      chk("tbl_rom_addr", rom_addr_o, tbl[i].raddr);
      chk("tbl_v_o", bus.v_o, tbl[i].vo);
      if (i == 1) chk("tbl_data_rom5", bus.data_o, rom_f(9'd5));
    end

    // Fairness between two constant requesters
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(3'b011, 9'd16, 9'd17, 9'd0, 3'b011);
      chk("fair_grant", bus.ready_o, (i % 2 == 0) ? 3'b001 : 3'b010);
    end

    // Burst lock keeps req1 waiting until req0's last beat
    do_reset();
    for (int b = 0; b < 4; b++) begin
      step(3'b011, 9'(8 + b), 9'd40, 9'd0, (b == 3) ? 3'b011 : 3'b010);
      chk("burst_ready", bus.ready_o, 3'b001);
    end
    step(3'b010, 9'd0, 9'd40, 9'd0, 3'b010);
    chk("burst_handover", bus.ready_o, 3'b010);

`ifdef BP_BOOT_ROM_ARB_LOCK_TIMEOUT_EN
    do_reset();
    step(3'b001, 9'd20, 9'd30, 9'd0, 3'b000);
    for (int i = 0; i < T; i++) begin
      step(3'b010, 9'd20, 9'd30, 9'd0, 3'b010);
      chk("to_hold_ready", bus.ready_o, 3'b001);
    end
    step(3'b010, 9'd20, 9'd30, 9'd0, 3'b010);
    chk("to_err_pulse", err_o, 1'b1);
    chk("to_req1_grant", bus.ready_o, 3'b010);
    step(3'b000, 9'd0, 9'd0, 9'd0, 3'b000);
    chk("to_err_once", err_o, 1'b0);
`else
    do_reset();
    step(3'b001, 9'd20, 9'd30, 9'd0, 3'b000);
    for (int i = 0; i < 10; i++) begin
      step(3'b010, 9'd20, 9'd30, 9'd0, 3'b010);
      chk("gap_ready", bus.ready_o, 3'b001);
      if (i > 0) chk("gap_no_v_o", bus.v_o, 3'b000);
    end
    step(3'b011, 9'd21, 9'd30, 9'd0, 3'b011);
    chk("gap_resume", bus.ready_o, 3'b001);
    step(3'b010, 9'd0, 9'd30, 9'd0, 3'b010);
    chk("gap_next", bus.ready_o, 3'b010);
`endif

    // Reset after the 2nd of 4 beats
    do_reset();
    step(3'b001, 9'd12, 9'd0, 9'd0, 3'b000);
    step(3'b001, 9'd13, 9'd0, 9'd0, 3'b000);
    @(negedge clk);
    bus.v_i = 3'b111;
    #1;
    chk("mid_pre_v_o", bus.v_o, 3'b001);
    chk("mid_pre_data", bus.data_o, rom_f(9'd13));
    reset_i = 1'b1;
    #1;
    chk("mid_rst_v_o", bus.v_o, 3'b000);
    chk("mid_rst_data", bus.data_o, '0);
    chk("mid_rst_ready", bus.ready_o, 3'b000);
    @(negedge clk);
    reset_i = 1'b0; bus.v_i = '0;
    m_reset();
    step(3'b011, 9'd14, 9'd15, 9'd0, 3'b011);
    chk("mid_first_grant", bus.ready_o, 3'b001);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(3'($urandom_range(0, 7)), 9'($urandom), 9'($urandom), 9'($urandom),
           3'($urandom | $urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_boot_rom_arbiter.md
BP_BOOT_ROM_ARBITER -- requirements
Module: bp_boot_rom_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2: number of requesters (CCEs) sharing one boot ROM, range 2..8.
REQ-002 SHALL have parameter addr_width_p, default 9: boot ROM address width.
REQ-003 SHALL have parameter width_p, default 512: boot ROM data width.
REQ-004 SHALL have parameter lock_timeout_p, default 64: idle-cycle limit for a held lock (used only under REQ-024).
REQ-005 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port v_i, input, num_req_p: per-requester request valid.
REQ-008 SHALL have port addr_i, input, num_req_p x addr_width_p: per-requester ROM address.
REQ-009 SHALL have port last_i, input, num_req_p: beat is the final beat of its burst.
REQ-010 SHALL have port ready_o, output, num_req_p: one-hot-or-zero grant; beat accepted when v_i[k] and ready_o[k].
REQ-011 SHALL have port v_o, output, num_req_p: one-hot-or-zero response valid.
REQ-012 SHALL have port data_o, output, width_p: response data shared by all requesters.
REQ-013 SHALL have port rom_addr_o, output, addr_width_p: address to the combinational boot ROM.
REQ-014 SHALL have port rom_data_i, input, width_p: combinational boot ROM read data.
REQ-015 SHALL have port err_o, output, 1: one-cycle pulse on lock timeout (REQ-024); tied 0 without the macro.

Function
REQ-016 SHALL implement states IDLE and LOCKED, plus registers rr_ptr (round-robin pointer) and owner.
REQ-017 In IDLE, ready_o SHALL be asserted combinationally for the first k with v_i[k]=1, searching from rr_ptr upward with wrap; ready_o SHALL be 0 when no v_i is set.
REQ-018 In LOCKED, ready_o SHALL equal one-hot(owner) regardless of v_i; no other requester is granted.
REQ-019 rom_addr_o SHALL equal addr_i[g] for the granted requester g, else 0.
REQ-020 On an accepted beat, rom_data_i SHALL be registered into data_o; v_o[g] SHALL be 1 in the next cycle only; latency is exactly 1 cycle; the response has no backpressure.
REQ-021 On an accepted beat with last_i[g]=0, the block SHALL go to (or stay in) LOCKED with owner=g.
REQ-022 On an accepted beat with last_i[g]=1, the block SHALL go to IDLE and set rr_ptr=(g+1) mod num_req_p, wrapping from num_req_p-1 to 0.
REQ-023 In LOCKED with v_i[owner]=0, the block SHALL hold state; data_o SHALL hold its last value whenever v_o=0.

Configuration
REQ-024 With BP_BOOT_ROM_ARB_LOCK_TIMEOUT_EN defined: a counter SHALL clear on every owner beat and increment each LOCKED cycle without an owner beat; when it reaches lock_timeout_p, the block SHALL return to IDLE, set rr_ptr=(owner+1) mod num_req_p, and pulse err_o for 1 cycle.
REQ-025 Without BP_BOOT_ROM_ARB_LOCK_TIMEOUT_EN: no counter SHALL be built, LOCKED SHALL persist indefinitely, and err_o SHALL be constant 0.

Reset
REQ-026 While reset_i=1 the block SHALL hold state=IDLE, rr_ptr=0, owner=0, timeout counter=0, and outputs v_o=0, data_o=0, err_o=0; ready_o SHALL be 0 during reset.
REQ-027 Reset asserted mid-burst SHALL drop the lock and any pending response immediately; the first cycle after deassertion SHALL arbitrate from rr_ptr=0.

Verification
REQ-028 Single beat: v_i=01, addr_i[0]=5, last_i=01 -> ready_o=01 the same cycle, rom_addr_o=5; next cycle v_o=01, data_o=ROM[5]; rr_ptr=1.
REQ-029 Fairness: v_i=11 held, all beats last=1, from reset -> grants alternate 0,1,0,1; each v_o pulse follows its grant by 1 cycle.
REQ-030 Burst lock: req0 sends 4 beats at addr 8..11 (last on the 4th) while v_i[1]=1 -> ready_o[1]=0 for all 4 beats; req1 is granted in the cycle after req0's last beat.
REQ-031 Owner gap: req0 locked, v_i[0]=0 for 10 cycles with v_i[1]=1 -> ready_o stays 01, no v_o pulses; req0 resumes and completes normally.
REQ-032 Timeout (macro on, lock_timeout_p=4): req0 locks and goes idle -> after 4 idle cycles err_o pulses once, state is IDLE, req1 is granted next.
REQ-033 Reset mid-burst: assert reset_i after the 2nd of 4 beats -> v_o=0 and data_o=0 immediately; after release, v_i=11 grants req0 first.
